// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data-memory stage. One access in flight at a time; the granted request's
// address/data/we are registered and held until the memory reports ready.
//
// state | meaning
// IDLE  | no access in flight; grant decision taken here when ena=1
// D_ACC | data access in flight, waiting for mem_rdy
// I_ACC | fetch access in flight, waiting for mem_rdy
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy,
  output logic              err_both
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              err_both_q, err_both_d;

  logic d_req_m;
  logic if_req_m;
  logic starve_full;
  logic gnt_data;
  logic gnt_fetch;

  // A requester is masked in its own valid cycle so it can present a new request
  assign d_req_m     = (d_read | d_write) & ~d_valid_q;
  assign if_req_m    = if_req & ~if_valid_q;
  assign starve_full = (starve_cnt_q == 4'(STARVE_MAX));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and grant decision; starved fetch beats data, otherwise data first
  always_comb begin
    state_d   = state_q;
    gnt_data  = 1'b0;
    gnt_fetch = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena) begin
          if (if_req_m && starve_full) begin
            gnt_fetch = 1'b1;
            state_d   = I_ACC;
          end else if (d_req_m) begin
            gnt_data = 1'b1;
            state_d  = D_ACC;
          end else if (if_req_m) begin
            gnt_fetch = 1'b1;
            state_d   = I_ACC;
          end
        end
      end
      D_ACC, I_ACC: begin
        if (mem_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; we is gated so it never shows outside an access
  always_comb begin
    mem_en = (state_q != IDLE);
    busy   = (state_q != IDLE);
    mem_we = (state_q == D_ACC) & we_q;
  end

  // Datapath next values: latch on grant, capture read data on completion
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    starve_cnt_d = starve_cnt_q;
    err_both_d   = err_both_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;

    if (gnt_data) begin
      addr_d  = d_addr;
      wdata_d = d_wdata;
      // read+write together resolves to a write and is flagged
      we_d    = d_write;
      if (d_read && d_write) err_both_d = 1'b1;
      if (if_req_m) begin
        if (!starve_full) starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = 4'd0;
      end
    end

    if (gnt_fetch) begin
      addr_d       = if_addr;
      we_d         = 1'b0;
      starve_cnt_d = 4'd0;
    end

    if (state_q == D_ACC && mem_rdy) begin
      d_valid_d = 1'b1;
      if (!we_q) d_rdata_d = mem_rdata;
    end

    if (state_q == I_ACC && mem_rdy) begin
      if_valid_d = 1'b1;
      if_rdata_d = mem_rdata;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      starve_cnt_q <= 4'd0;
      err_both_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      starve_cnt_q <= starve_cnt_d;
      err_both_q   <= err_both_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign err_both  = err_both_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = (d_read | d_write) & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;
  logic        err_both;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy), .err_both(err_both)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the memory (0 none, 1 data, 2 fetch) and the
  // transaction latched at grant time.
  int          m_own;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit          m_we, m_iv, m_dv, m_err;
  int          m_starve;

  task automatic model_reset();
    m_own = 0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    m_we = 0; m_iv = 0; m_dv = 0; m_err = 0; m_starve = 0;
  endtask

  task automatic grant_fetch();
    m_own = 2; m_addr = if_addr; m_we = 0; m_starve = 0;
  endtask

  task automatic model_step();
    bit dm, im;
    if (!rst) begin
      model_reset();
      return;
    end
    dm = (d_read || d_write) && !m_dv;
    im = if_req && !m_iv;
    m_iv = 0;
    m_dv = 0;
    if (m_own == 1) begin
      if (mem_rdy) begin
        m_dv = 1;
        if (!m_we) m_drdata = mem_rdata;
        m_own = 0;
      end
    end else if (m_own == 2) begin
      if (mem_rdy) begin
        m_iv = 1;
        m_irdata = mem_rdata;
        m_own = 0;
      end
    end else if (ena) begin
      if (im && m_starve == STARVE_MAX) grant_fetch();
      else if (dm) begin
        m_own = 1; m_addr = d_addr; m_wdata = d_wdata; m_we = d_write;
        if (d_read && d_write) m_err = 1;
        m_starve = im ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
      end else if (im) grant_fetch();
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mem_en",    64'(mem_en),    64'(m_own != 0));
    chk("busy",      64'(busy),      64'(m_own != 0));
    chk("mem_we",    64'(mem_we),    64'(m_own == 1 && m_we));
    chk("if_valid",  64'(if_valid),  64'(m_iv));
    chk("d_valid",   64'(d_valid),   64'(m_dv));
    chk("if_rdata",  64'(if_rdata),  64'(m_irdata));
    chk("d_rdata",   64'(d_rdata),   64'(m_drdata));
    chk("err_both",  64'(err_both),  64'(m_err));
    chk("stall_if",  64'(stall_if),  64'(if_req && !m_iv));
    chk("stall_mem", 64'(stall_mem), 64'((d_read || d_write) && !m_dv));
    if (m_own != 0) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    if (m_own == 1 && m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
  endtask

  // One clock cycle: inputs already applied after the falling edge
  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int dv_at, iv_at, ng, got, prev_en, seen, r;

  initial begin
    rst = 1'b0; ena = 1'b1; if_req = 0; if_addr = '0; d_read = 0; d_write = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_rdy = 0;
    model_reset();
    @(negedge clk);
    cyc();
    #1;
    chk("rst.mem_addr", 64'(mem_addr), 64'h0);
    chk("rst.mem_wdata", 64'(mem_wdata), 64'h0);
    cyc();
    rst = 1'b1;
    cyc();

    // Load: grant in cycle 0, mem_en in 1, d_valid in 2
    d_read = 1; d_addr = 32'h40; mem_rdy = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1.c0.stall_mem", 64'(stall_mem), 64'h1);
    chk("t1.c0.mem_en", 64'(mem_en), 64'h0);
    cyc();
    #1;
    chk("t1.c1.mem_en", 64'(mem_en), 64'h1);
    chk("t1.c1.stall_mem", 64'(stall_mem), 64'h1);
    cyc();
    #1;
    chk("t1.c2.d_valid", 64'(d_valid), 64'h1);
    chk("t1.c2.d_rdata", 64'(d_rdata), 64'hDEADBEEF);
    chk("t1.c2.stall_mem", 64'(stall_mem), 64'h0);
    d_read = 0;
    cyc();
    cyc();

    // Simultaneous requests: data first, fetch granted in the d_valid cycle
    if_req = 1; if_addr = 32'h100; d_read = 1; d_addr = 32'h44; mem_rdata = 32'hA5A50001;
    dv_at = -1; iv_at = -1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 1) chk("t2.first_grant_addr", 64'(mem_addr), 64'h44);
      if (d_valid && dv_at < 0) dv_at = k;
      if (if_valid && iv_at < 0) iv_at = k;
      if (m_dv) d_read = 0;
      if (m_iv) if_req = 0;
      mem_rdata = mem_rdata + 32'd1;
      cyc();
    end
    // fetch granted in cycle 2, mem_en in 3, if_valid in 4
    chk("t2.d_valid_cycle", 64'(dv_at), 64'd2);
    chk("t2.if_valid_cycle", 64'(iv_at), 64'd4);

    // Starvation guard: ena low in each d_valid cycle lets data win repeatedly
    do_reset();
    if_req = 1; if_addr = 32'h200; d_read = 1; d_addr = 32'h300; mem_rdy = 1;
    ng = 0; got = 0; prev_en = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      ena = !m_dv;
      #1;
      if (mem_en && !prev_en) begin
        if (mem_addr == 32'h200) got = 1;
        else ng++;
      end
      prev_en = int'(mem_en);
      cyc();
    end
    chk("t3.fetch_granted", 64'(got), 64'h1);
    chk("t3.data_grants", 64'(ng), 64'd4);
    ena = 1;
    for (int k = 0; k < 8; k++) begin
      if (m_iv) if_req = 0;
      if (m_dv) d_read = 0;
      cyc();
    end

    // Slow store with ena dropped mid-access
    d_write = 1; d_addr = 32'h80; d_wdata = 32'h12345678; mem_rdy = 0; if_req = 0;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      mem_rdy = (k == 6);
      if (k >= 2) ena = 0;
      if_req = 1; if_addr = 32'h600;
      d_wdata = $urandom; d_addr = $urandom;
      #1;
      chk("t4.mem_we", 64'(mem_we), 64'h1);
      chk("t4.mem_addr", 64'(mem_addr), 64'h80);
      chk("t4.mem_wdata", 64'(mem_wdata), 64'h12345678);
      cyc();
    end
    #1;
    chk("t4.d_valid", 64'(d_valid), 64'h1);
    d_write = 0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4.no_grant", 64'(mem_en), 64'h0);
      cyc();
    end
    ena = 1; mem_rdy = 1;
    for (int k = 0; k < 6; k++) begin
      if (m_iv) if_req = 0;
      cyc();
    end

    // Reset while a fetch is in flight
    if_req = 1; if_addr = 32'h500; mem_rdy = 0;
    cyc();
    cyc();
    rst = 0;
    model_reset();
    #1;
    chk("t5.mem_en", 64'(mem_en), 64'h0);
    chk("t5.busy", 64'(busy), 64'h0);
    chk("t5.if_valid", 64'(if_valid), 64'h0);
    cyc();
    rst = 1; mem_rdy = 1; mem_rdata = 32'hCAFEF00D; seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      #1;
      if (if_valid) begin
        seen = 1;
        chk("t5.if_rdata", 64'(if_rdata), 64'hCAFEF00D);
      end
      if (m_iv) if_req = 0;
      cyc();
    end
    chk("t5.refetch_done", 64'(seen), 64'h1);

    // Read and write together at grant
    d_read = 1; d_write = 1; d_addr = 32'h90; d_wdata = 32'h0BADF00D; mem_rdy = 1;
    cyc();
    #1;
    chk("t6.mem_we", 64'(mem_we), 64'h1);
    chk("t6.mem_wdata", 64'(mem_wdata), 64'h0BADF00D);
    cyc();
    #1;
    chk("t6.d_valid", 64'(d_valid), 64'h1);
    chk("t6.err_both", 64'(err_both), 64'h1);
    d_read = 0; d_write = 0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6.err_sticky", 64'(err_both), 64'h1);
      cyc();
    end
    do_reset();
    #1;
    chk("t6.err_cleared", 64'(err_both), 64'h0);

    // Random traffic: requesters hold until served, may re-request in valid cycle
    for (int k = 0; k < 3000; k++) begin
      ena = ($urandom % 8) != 0;
      mem_rdy = ($urandom % 3) != 0;
      mem_rdata = $urandom;
      if (!if_req || m_iv) begin
        if_req = ($urandom % 3) != 0;
        if_addr = $urandom;
      end
      if (!(d_read || d_write) || m_dv) begin
        r = int'($urandom % 16);
        d_read = (r >= 4 && r <= 9) || r == 15;
        d_write = (r >= 10);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
